// File: rtl/exibe_sequencia_if.sv
// Signal bundle between the game's top-level FSM / sequence ROM (master)
// and the sequence presenter (slave).
interface exibe_sequencia_if;
  logic       iniciar;    // start request
  logic       cancela;    // synchronous abort
  logic [3:0] limite;     // last ROM address to show
  logic [3:0] dado;       // ROM data_out, registered
  logic [3:0] endereco;   // ROM address
  logic [3:0] leds;       // displayed value
  logic       ocupado;    // busy (any state but INICIAL)
  logic       pronto;     // one-cycle end-of-sequence pulse
  logic [2:0] db_estado;  // debug: current state code

  modport master (
    output iniciar, cancela, limite, dado,
    input  endereco, leds, ocupado, pronto, db_estado
  );

  modport slave (
    input  iniciar, cancela, limite, dado,
    output endereco, leds, ocupado, pronto, db_estado
  );
endinterface

// File: rtl/exibe_sequencia.sv
// Sequence presenter for the memory game: walks ROM addresses 0..limite,
// lighting each entry for TEMPO_ON cycles followed by a TEMPO_OFF blank gap,
// then pulses pronto for one cycle.
module exibe_sequencia #(
  parameter int TEMPO_ON  = 500,
  parameter int TEMPO_OFF = 250,
  parameter int TW        = 16
) (
  input logic               clock,
  input logic               reset,
  exibe_sequencia_if.slave  bus
);

  typedef enum logic [2:0] {
    INICIAL = 3'd0,
    CARREGA = 3'd1,
    MOSTRA  = 3'd2,
    APAGA   = 3'd3,
    FIM     = 3'd4
  } estado_t;

  localparam logic [TW-1:0] ON_LAST  = TW'(TEMPO_ON - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(TEMPO_OFF - 1);

  estado_t       estado_q,   estado_d;
  logic [3:0]    endereco_q, endereco_d;
  logic [3:0]    limite_q,   limite_d;
  logic [TW-1:0] timer_q,    timer_d;

  // State, address, latched limit and phase timer registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge snapshot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= INICIAL;
      endereco_q <= 4'd0;
      limite_q   <= 4'd0;
      timer_q    <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      limite_q   <= limite_d;
      timer_q    <= timer_d;
    end
  end

  // Next-state logic: sequencing through load, lit and blank phases; cancela
  // overrides everything and leaves the address where it was.
  // NOTE: every signal gets a hold/default value before the case so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    limite_d   = limite_q;
    timer_d    = timer_q;

    case (estado_q)
      INICIAL: begin
        timer_d = '0;
        if (bus.iniciar) begin
          endereco_d = 4'd0;
          limite_d   = bus.limite;
          estado_d   = CARREGA;
        end
      end
      CARREGA: begin
        // Address is held through this cycle so the ROM output is valid
        // for the whole of MOSTRA.
        timer_d  = '0;
        estado_d = MOSTRA;
      end
      MOSTRA: begin
        if (timer_q == ON_LAST) begin
          timer_d  = '0;
          estado_d = APAGA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      APAGA: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (endereco_q == limite_q) begin
            estado_d = FIM;
          end else begin
            endereco_d = endereco_q + 4'd1;
            estado_d   = CARREGA;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FIM: begin
        estado_d = INICIAL;
      end
      default: begin
        timer_d  = '0;
        estado_d = INICIAL;
      end
    endcase

    if (bus.cancela) begin
      estado_d   = INICIAL;
      timer_d    = '0;
      endereco_d = endereco_q;
      limite_d   = limite_q;
    end
  end

  // Outputs are pure decodes of the current state.
  assign bus.endereco  = endereco_q;
  assign bus.leds      = (estado_q == MOSTRA) ? bus.dado : 4'd0;
  assign bus.ocupado   = (estado_q != INICIAL);
  assign bus.pronto    = (estado_q == FIM);
  assign bus.db_estado = estado_q;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Scoreboard bench for exibe_sequencia with TEMPO_ON=4, TEMPO_OFF=2 and a
// 16x4 synchronous ROM holding 1,2,4,8 repeated.
module tb_exibe_sequencia;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int PER = 1 + ON + OFF;  // cycles per entry

  // ROM contents, also the expected lit values.
  localparam logic [3:0] ROM_TBL [16] = '{
    4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8,
    4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8
  };

  typedef struct {
    bit         is_pronto;
    logic [3:0] val;
    logic [3:0] addr;
    int         start;
    int         len;
  } ev_t;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  ev_t  sb[$];

  exibe_sequencia_if bus ();

  exibe_sequencia #(
    .TEMPO_ON (ON),
    .TEMPO_OFF(OFF),
    .TW       (16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous ROM, one-cycle read latency.
  always @(posedge clock) bus.dado <= ROM_TBL[bus.endereco];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare(input ev_t got);
    ev_t e;
    if (sb.size() == 0) begin
      check(got.is_pronto ? "unexpected_pronto" : "unexpected_window", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("event_kind", 32'(got.is_pronto), 32'(e.is_pronto));
    check(got.is_pronto ? "pronto_cycle" : "window_start", got.start, e.start);
    if (!e.is_pronto && !got.is_pronto) begin
      check("window_value", 32'(got.val), 32'(e.val));
      check("window_addr", 32'(got.addr), 32'(e.addr));
      check("window_len", got.len, e.len);
    end
  endtask

  // Monitor: groups consecutive lit cycles into windows and reports every
  // pronto pulse; each becomes one scoreboard event.
  bit  in_win = 1'b0;
  ev_t cur;
  always @(negedge clock) begin
    ev_t p;
    if (bus.leds !== 4'd0) begin
      if (in_win && bus.leds !== cur.val) begin
        compare(cur);
        in_win = 1'b0;
      end
      if (!in_win) begin
        in_win        = 1'b1;
        cur.is_pronto = 1'b0;
        cur.val       = bus.leds;
        cur.addr      = bus.endereco;
        cur.start     = cyc;
        cur.len       = 1;
      end else begin
        cur.len++;
      end
    end else if (in_win) begin
      in_win = 1'b0;
      compare(cur);
    end
    if (bus.pronto === 1'b1) begin
      p.is_pronto = 1'b1;
      p.val       = 4'd0;
      p.addr      = 4'd0;
      p.start     = cyc;
      p.len       = 0;
      compare(p);
    end
  end

  // Cycle k after the start edge is observed with cyc == e0 + k - 1.
  task automatic push_window(input int a, input int start, input int len);
    ev_t e;
    e.is_pronto = 1'b0;
    e.val       = ROM_TBL[a];
    e.addr      = 4'(a);
    e.start     = start;
    e.len       = len;
    sb.push_back(e);
  endtask

  task automatic push_pronto(input int at);
    ev_t e;
    e.is_pronto = 1'b1;
    e.val       = 4'd0;
    e.addr      = 4'd0;
    e.start     = at;
    e.len       = 0;
    sb.push_back(e);
  endtask

  task automatic push_seq(input int e0, input int lim);
    for (int i = 0; i <= lim; i++) push_window(i, e0 + i * PER + 1, ON);
    push_pronto(e0 + (lim + 1) * PER);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clock);
  endtask

  // Pulses iniciar for one edge; returns in cycle 1 with e0 = start edge count.
  task automatic start(input logic [3:0] lim, output int e0);
    @(negedge clock);
    bus.limite  = lim;
    bus.iniciar = 1'b1;
    e0 = cyc + 1;
    @(negedge clock);
    bus.iniciar = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e0;
    int zero_seen;

    reset       = 1'b1;
    bus.iniciar = 1'b0;
    bus.cancela = 1'b0;
    bus.limite  = 4'd0;
    #1;
    check("reset.ocupado", 32'(bus.ocupado), 0);
    check("reset.leds", 32'(bus.leds), 0);
    check("reset.pronto", 32'(bus.pronto), 0);
    check("reset.endereco", 32'(bus.endereco), 0);
    check("reset.db_estado", 32'(bus.db_estado), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // iniciar and cancela together in INICIAL: cancela wins.
    @(negedge clock);
    bus.iniciar = 1'b1;
    bus.cancela = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    bus.cancela = 1'b0;
    check("both.ocupado", 32'(bus.ocupado), 0);
    check("both.db_estado", 32'(bus.db_estado), 0);

    // Single entry, limite=0.
    start(4'd0, e0);
    push_seq(e0, 0);
    check("single.ocupado_c1", 32'(bus.ocupado), 1);
    check("single.db_carrega", 32'(bus.db_estado), 1);
    wait_cyc(e0 + 2);
    check("single.db_mostra", 32'(bus.db_estado), 2);
    check("single.leds_c3", 32'(bus.leds), 1);
    wait_cyc(e0 + 5);
    check("single.db_apaga", 32'(bus.db_estado), 3);
    check("single.leds_c6", 32'(bus.leds), 0);
    wait_cyc(e0 + 7);
    check("single.pronto_c8", 32'(bus.pronto), 1);
    check("single.db_fim", 32'(bus.db_estado), 4);
    wait_cyc(e0 + 8);
    check("single.ocupado_c9", 32'(bus.ocupado), 0);
    check("single.pronto_c9", 32'(bus.pronto), 0);

    // Full sequence, limite=15: address must never return to 0.
    start(4'd15, e0);
    push_seq(e0, 15);
    zero_seen = 0;
    wait_cyc(e0 + PER);
    while (cyc < e0 + 16 * PER + 2) begin
      if (bus.endereco == 4'd0) zero_seen++;
      @(negedge clock);
    end
    check("full.no_wrap", zero_seen, 0);
    check("full.endereco_end", 32'(bus.endereco), 15);
    check("full.ocupado_end", 32'(bus.ocupado), 0);

    // Retrigger while busy is ignored.
    start(4'd2, e0);
    push_seq(e0, 2);
    wait_cyc(e0 + 2);
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    wait_cyc(e0 + 9);
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    wait_cyc(e0 + 23);
    check("retrig.ocupado_end", 32'(bus.ocupado), 0);

    // Cancel during the second entry's lit phase (cycle 9).
    start(4'd5, e0);
    push_window(0, e0 + 1, ON);
    push_window(1, e0 + 8, 1);
    wait_cyc(e0 + 8);
    bus.cancela = 1'b1;
    @(negedge clock);
    bus.cancela = 1'b0;
    check("cancel.ocupado", 32'(bus.ocupado), 0);
    check("cancel.db_estado", 32'(bus.db_estado), 0);
    check("cancel.leds", 32'(bus.leds), 0);
    check("cancel.endereco_held", 32'(bus.endereco), 1);
    repeat (10) @(negedge clock);
    start(4'd0, e0);
    push_seq(e0, 0);
    check("cancel.restart_addr", 32'(bus.endereco), 0);
    wait_cyc(e0 + PER + 2);

    // limite changed mid-sequence has no effect.
    start(4'd1, e0);
    push_seq(e0, 1);
    wait_cyc(e0 + 3);
    bus.limite = 4'd15;
    wait_cyc(e0 + 16);
    check("limchg.ocupado_end", 32'(bus.ocupado), 0);
    check("limchg.endereco_end", 32'(bus.endereco), 1);

    // Asynchronous reset during the second entry's lit phase.
    start(4'd3, e0);
    push_window(0, e0 + 1, ON);
    push_window(1, e0 + 8, 2);
    wait_cyc(e0 + 9);
    check("rstmid.endereco_before", 32'(bus.endereco), 1);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid.leds", 32'(bus.leds), 0);
    check("rstmid.ocupado", 32'(bus.ocupado), 0);
    check("rstmid.endereco", 32'(bus.endereco), 0);
    check("rstmid.db_estado", 32'(bus.db_estado), 0);
    check("rstmid.pronto", 32'(bus.pronto), 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
